// File: rtl/btb_sram_1r1w.sv
// btb_sram_1r1w: parametrised 1-read/1-write synchronous array for BTB/eBTB storage.
//
// After reset the array runs an init sweep that writes zero to every entry
// (DEPTH cycles, init_busy=1). Read and write requests are dropped during the
// sweep. When the sweep is done, writes honour a per-lane mask, and reads return
// data READ_LAT cycles later (1 or 2) with a matching r_valid pulse.
//
// Optional feature macro: BTB_SRAM_BYPASS_EN
//   undefined : a read and a write to the same address in the same cycle return the old contents
//   defined   : that read returns the merged value (masked lanes from w_data, the rest old data)
//
// Ports:
//   clock      sole clock
//   reset_n    asynchronous active-low reset
//   r_en       read request
//   r_addr     read address [AW-1:0]
//   r_valid    r_data holds the result of the request issued READ_LAT cycles earlier
//   r_data     read data [WIDTH-1:0]; keeps its last value while r_valid=0
//   w_en       write request
//   w_addr     write address [AW-1:0]
//   w_data     write data [WIDTH-1:0]
//   w_mask     lane write enables [NL-1:0]; lane i covers bits [i*MASK_GRAN +: MASK_GRAN]
//   init_busy  init sweep in progress
module btb_sram_1r1w #(
    parameter int unsigned DEPTH     = 128,
    parameter int unsigned WIDTH     = 40,
    parameter int unsigned MASK_GRAN = 8,
    parameter int unsigned READ_LAT  = 1,
    localparam int unsigned AW       = $clog2(DEPTH),
    localparam int unsigned NL       = WIDTH / MASK_GRAN
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             r_en,
    input  logic [AW-1:0]    r_addr,
    output logic             r_valid,
    output logic [WIDTH-1:0] r_data,
    input  logic             w_en,
    input  logic [AW-1:0]    w_addr,
    input  logic [WIDTH-1:0] w_data,
    input  logic [NL-1:0]    w_mask,
    output logic             init_busy
);

    if ((WIDTH % MASK_GRAN) != 0) begin : g_err_gran
        $error("btb_sram_1r1w: WIDTH must be a multiple of MASK_GRAN");
    end
    if ((READ_LAT != 1) && (READ_LAT != 2)) begin : g_err_lat
        $error("btb_sram_1r1w: READ_LAT must be 1 or 2");
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_err_depth
        $error("btb_sram_1r1w: DEPTH must be a power of two >= 2");
    end

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    state_t            state, state_next;
    logic [AW-1:0]     cnt, cnt_next;
    logic              sweep_we;
    logic              wr_fire;
    logic              rd_fire;
    logic [WIDTH-1:0]  wbits;
    logic [WIDTH-1:0]  rd_word;
    logic              s1_valid;
    logic [WIDTH-1:0]  s1_data;

    logic [WIDTH-1:0]  mem [DEPTH];

    // ------------------------------------------------------------------
    // Init sweep FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        init_busy  = 1'b0;
        sweep_we   = 1'b0;
        case (state)
            CLEAR: begin
                init_busy = 1'b1;
                sweep_we  = 1'b1;
                cnt_next  = cnt + AW'(1);
                if (cnt == AW'(DEPTH - 1)) begin
                    state_next = READY;
                    cnt_next   = '0;
                end
            end
            READY: begin
                state_next = READY;
            end
            default: begin
                state_next = CLEAR;
                cnt_next   = '0;
            end
        endcase
    end

    assign wr_fire = (state == READY) && w_en;
    assign rd_fire = (state == READY) && r_en;

    // Expand lane mask to a bit mask
    always_comb begin
        wbits = '0;
        for (int unsigned i = 0; i < NL; i++) begin
            wbits[i*MASK_GRAN +: MASK_GRAN] = {MASK_GRAN{w_mask[i]}};
        end
    end

    // ------------------------------------------------------------------
    // Storage: no reset on contents; the sweep clears them
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (sweep_we) begin
            mem[cnt] <= '0;
        end else if (wr_fire) begin
            mem[w_addr] <= (mem[w_addr] & ~wbits) | (w_data & wbits);
        end
    end

    // Array sampled in the request cycle
    always_comb begin
        rd_word = mem[r_addr];
`ifdef BTB_SRAM_BYPASS_EN
        if (wr_fire && (w_addr == r_addr)) begin
            rd_word = (rd_word & ~wbits) | (w_data & wbits);
        end
`endif
    end

    // ------------------------------------------------------------------
    // Read pipeline; data registers only load on a valid beat so r_data
    // keeps the last returned value
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= rd_fire;
            if (rd_fire) begin
                s1_data <= rd_word;
            end
        end
    end

    if (READ_LAT == 2) begin : g_lat2
        logic             s2_valid;
        logic [WIDTH-1:0] s2_data;

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                s2_valid <= 1'b0;
                s2_data  <= '0;
            end else begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_data <= s1_data;
                end
            end
        end

        assign r_valid = s2_valid;
        assign r_data  = s2_data;
    end else begin : g_lat1
        assign r_valid = s1_valid;
        assign r_data  = s1_data;
    end

endmodule

// File: tb/tb_btb_sram_1r1w.sv
// tb_btb_sram_1r1w: directed bench for btb_sram_1r1w.
// Two instances share all inputs: dut1 with READ_LAT=1, dut2 with READ_LAT=2.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_btb_sram_1r1w;

    logic        clock;
    logic        reset_n;
    logic        r_en;
    logic [6:0]  r_addr;
    logic        w_en;
    logic [6:0]  w_addr;
    logic [39:0] w_data;
    logic [4:0]  w_mask;

    logic        r_valid1, r_valid2;
    logic [39:0] r_data1, r_data2;
    logic        init_busy1, init_busy2;

    int checks = 0;
    int errors = 0;

    btb_sram_1r1w #(.DEPTH(128), .WIDTH(40), .MASK_GRAN(8), .READ_LAT(1)) dut1 (
        .clock(clock), .reset_n(reset_n),
        .r_en(r_en), .r_addr(r_addr), .r_valid(r_valid1), .r_data(r_data1),
        .w_en(w_en), .w_addr(w_addr), .w_data(w_data), .w_mask(w_mask),
        .init_busy(init_busy1)
    );

    btb_sram_1r1w #(.DEPTH(128), .WIDTH(40), .MASK_GRAN(8), .READ_LAT(2)) dut2 (
        .clock(clock), .reset_n(reset_n),
        .r_en(r_en), .r_addr(r_addr), .r_valid(r_valid2), .r_data(r_data2),
        .w_en(w_en), .w_addr(w_addr), .w_data(w_data), .w_mask(w_mask),
        .init_busy(init_busy2)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive-only helpers (no checking inside)
    task automatic do_write(input logic [6:0] a, input logic [39:0] d, input logic [4:0] m);
        w_en = 1'b1; w_addr = a; w_data = d; w_mask = m;
        @(negedge clock);
        w_en = 1'b0; w_mask = '0;
    endtask

    task automatic do_read1(input logic [6:0] a, output logic v, output logic [39:0] d);
        r_en = 1'b1; r_addr = a;
        @(negedge clock);
        r_en = 1'b0;
        v = r_valid1;
        d = r_data1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0; r_en = 1'b0; r_addr = '0;
        w_en = 1'b0; w_addr = '0; w_data = '0; w_mask = '0;
        repeat (3) @(negedge clock);
        checks++;
        if (init_busy1 !== 1'b1) begin errors++; $display("FAIL reset_init_busy: got %b expected 1", init_busy1); end
        checks++;
        if (r_valid1 !== 1'b0) begin errors++; $display("FAIL reset_r_valid1: got %b expected 0", r_valid1); end
        checks++;
        if (r_data1 !== 40'h0) begin errors++; $display("FAIL reset_r_data1: got %h expected 0", r_data1); end
        checks++;
        if (r_valid2 !== 1'b0) begin errors++; $display("FAIL reset_r_valid2: got %b expected 0", r_valid2); end
        checks++;
        if (r_data2 !== 40'h0) begin errors++; $display("FAIL reset_r_data2: got %h expected 0", r_data2); end
    endtask

    task automatic test_init_sweep;
        int n;
        logic v;
        logic [39:0] d;
        reset_n = 1'b1;
        n = 0;
        while (init_busy1 === 1'b1 && n < 300) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (n != 128) begin errors++; $display("FAIL init_busy_cycles: got %0d expected 128", n); end
        for (int i = 0; i < 128; i++) begin
            do_read1(7'(i), v, d);
            checks++;
            if (v !== 1'b1 || d !== 40'h0) begin
                errors++; $display("FAIL sweep_read[%0d]: got v=%b d=%h expected v=1 d=0", i, v, d);
            end
            @(negedge clock);
            checks++;
            if (r_valid1 !== 1'b0) begin errors++; $display("FAIL sweep_pulse[%0d]: got %b expected 0", i, r_valid1); end
        end
    endtask

    task automatic test_write_read;
        logic v;
        logic [39:0] d;
        do_write(7'd5, 40'h12_3456_789A, 5'b11111);
        do_read1(7'd5, v, d);
        checks++;
        if (v !== 1'b1 || d !== 40'h12_3456_789A) begin
            errors++; $display("FAIL write_read: got v=%b d=%h expected v=1 d=123456789a", v, d);
        end
        @(negedge clock);
        checks++;
        if (r_valid1 !== 1'b0 || r_data1 !== 40'h12_3456_789A) begin
            errors++; $display("FAIL hold_data: got v=%b d=%h expected v=0 d=123456789a", r_valid1, r_data1);
        end
    endtask

    task automatic test_mask;
        logic v;
        logic [39:0] d;
        do_write(7'd5, 40'hFF_FFFF_FFFF, 5'b00001);
        do_read1(7'd5, v, d);
        checks++;
        if (v !== 1'b1 || d !== 40'h12_3456_78FF) begin
            errors++; $display("FAIL mask_lane0: got v=%b d=%h expected v=1 d=12345678ff", v, d);
        end
        do_write(7'd5, 40'h00_0000_0000, 5'b00000);
        do_read1(7'd5, v, d);
        checks++;
        if (d !== 40'h12_3456_78FF) begin errors++; $display("FAIL mask_zero: got %h expected 12345678ff", d); end
        do_write(7'd5, 40'hAB_0000_0000, 5'b10000);
        do_read1(7'd5, v, d);
        checks++;
        if (d !== 40'hAB_3456_78FF) begin errors++; $display("FAIL mask_lane4: got %h expected ab345678ff", d); end
    endtask

    task automatic test_same_cycle;
        logic v;
        logic [39:0] d;
        logic [39:0] exp_full, exp_merge;
`ifdef BTB_SRAM_BYPASS_EN
        exp_full  = 40'h55_5555_5555;
        exp_merge = 40'h55_5555_0055;
`else
        exp_full  = 40'hAA_AAAA_AAAA;
        exp_merge = 40'h55_5555_5555;
`endif
        do_write(7'd7, 40'hAA_AAAA_AAAA, 5'b11111);
        w_en = 1'b1; w_addr = 7'd7; w_data = 40'h55_5555_5555; w_mask = 5'b11111;
        r_en = 1'b1; r_addr = 7'd7;
        @(negedge clock);
        w_en = 1'b0; r_en = 1'b0; w_mask = '0;
        checks++;
        if (r_valid1 !== 1'b1 || r_data1 !== exp_full) begin
            errors++; $display("FAIL same_addr_full: got v=%b d=%h expected v=1 d=%h", r_valid1, r_data1, exp_full);
        end
        do_read1(7'd7, v, d);
        checks++;
        if (d !== 40'h55_5555_5555) begin errors++; $display("FAIL same_addr_after: got %h expected 5555555555", d); end
        w_en = 1'b1; w_addr = 7'd7; w_data = 40'h00_0000_0000; w_mask = 5'b00010;
        r_en = 1'b1; r_addr = 7'd7;
        @(negedge clock);
        w_en = 1'b0; r_en = 1'b0; w_mask = '0;
        checks++;
        if (r_data1 !== exp_merge) begin
            errors++; $display("FAIL same_addr_masked: got %h expected %h", r_data1, exp_merge);
        end
        do_read1(7'd7, v, d);
        checks++;
        if (d !== 40'h55_5555_0055) begin errors++; $display("FAIL masked_after: got %h expected 5555550055", d); end
        w_en = 1'b1; w_addr = 7'd9; w_data = 40'h01_0203_0405; w_mask = 5'b11111;
        r_en = 1'b1; r_addr = 7'd5;
        @(negedge clock);
        w_en = 1'b0; r_en = 1'b0; w_mask = '0;
        checks++;
        if (r_data1 !== 40'hAB_3456_78FF) begin errors++; $display("FAIL diff_addr_read: got %h expected ab345678ff", r_data1); end
        do_read1(7'd9, v, d);
        checks++;
        if (d !== 40'h01_0203_0405) begin errors++; $display("FAIL diff_addr_write: got %h expected 0102030405", d); end
    endtask

    task automatic test_lat2_pipeline;
        logic [39:0] vals [4];
        logic v;
        logic [39:0] d;
        vals[0] = 40'h10_0000_0001;
        vals[1] = 40'h20_0000_0002;
        vals[2] = 40'h30_0000_0003;
        vals[3] = 40'h40_0000_0004;
        for (int i = 0; i < 4; i++) do_write(7'(i), vals[i], 5'b11111);
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (i >= 2 && i <= 5) begin
                if (r_valid2 !== 1'b1 || r_data2 !== vals[i-2]) begin
                    errors++; $display("FAIL lat2_beat[%0d]: got v=%b d=%h expected v=1 d=%h", i, r_valid2, r_data2, vals[i-2]);
                end
            end else if (r_valid2 !== 1'b0) begin
                errors++; $display("FAIL lat2_idle[%0d]: got v=%b expected v=0", i, r_valid2);
            end
            r_en = (i < 4); r_addr = 7'(i);
            // Overwrite addr 0 one cycle after its read was sampled
            w_en = (i == 1); w_addr = 7'd0; w_data = 40'hEE_EEEE_EEEE; w_mask = 5'b11111;
            @(negedge clock);
        end
        r_en = 1'b0; w_en = 1'b0; w_mask = '0;
        do_read1(7'd0, v, d);
        checks++;
        if (d !== 40'hEE_EEEE_EEEE) begin errors++; $display("FAIL lat2_late_write: got %h expected eeeeeeeeee", d); end
    endtask

    task automatic test_reset_inflight;
        r_en = 1'b1; r_addr = 7'd1;
        @(negedge clock);
        r_addr = 7'd2;
        @(negedge clock);
        r_en = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (r_valid2 !== 1'b0 || r_data2 !== 40'h0) begin
            errors++; $display("FAIL inflight_reset2: got v=%b d=%h expected v=0 d=0", r_valid2, r_data2);
        end
        checks++;
        if (r_valid1 !== 1'b0 || init_busy1 !== 1'b1) begin
            errors++; $display("FAIL inflight_reset1: got v=%b busy=%b expected v=0 busy=1", r_valid1, init_busy1);
        end
        @(negedge clock);
        checks++;
        if (r_valid2 !== 1'b0 || r_data2 !== 40'h0) begin
            errors++; $display("FAIL inflight_discard: got v=%b d=%h expected v=0 d=0", r_valid2, r_data2);
        end
    endtask

    task automatic test_reset_mid_sweep;
        int n;
        logic v;
        logic [39:0] d;
        reset_n = 1'b1;
        for (int k = 0; k < 60; k++) begin
            r_en = 1'b1; r_addr = 7'(k);
            w_en = 1'b1; w_addr = 7'd0; w_data = 40'hFF_FFFF_FFFF; w_mask = 5'b11111;
            @(negedge clock);
            checks++;
            if (r_valid1 !== 1'b0 || init_busy1 !== 1'b1) begin
                errors++; $display("FAIL sweep1_drop[%0d]: got v=%b busy=%b expected v=0 busy=1", k, r_valid1, init_busy1);
            end
        end
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        n = 0;
        while (init_busy1 === 1'b1 && n < 300) begin
            r_en = 1'b1; r_addr = 7'd3;
            w_en = 1'b1; w_addr = 7'((n % 2 == 0) ? 3 : 0); w_data = 40'hFF_FFFF_FFFF; w_mask = 5'b11111;
            @(negedge clock);
            n++;
            checks++;
            if (r_valid1 !== 1'b0 || r_valid2 !== 1'b0) begin
                errors++; $display("FAIL sweep2_drop[%0d]: got v1=%b v2=%b expected 0", n, r_valid1, r_valid2);
            end
        end
        r_en = 1'b0; w_en = 1'b0; w_mask = '0;
        checks++;
        if (n != 128) begin errors++; $display("FAIL restart_busy_cycles: got %0d expected 128", n); end
        for (int i = 0; i < 128; i++) begin
            do_read1(7'(i), v, d);
            checks++;
            if (v !== 1'b1 || d !== 40'h0) begin
                errors++; $display("FAIL post_sweep_read[%0d]: got v=%b d=%h expected v=1 d=0", i, v, d);
            end
        end
    endtask

    initial begin
        test_reset;
        test_init_sweep;
        test_write_read;
        test_mask;
        test_same_cycle;
        test_lat2_pipeline;
        test_reset_inflight;
        test_reset_mid_sweep;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
